// File: rtl/request_tagger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : types_def (package)
// Description : Shared request-type, tag-space and front-end state types for
//               request_tagger.
// Revision    : 1.0 - initial release
// ============================================================================
package types_def;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    localparam int read_entries_log  = 6;
    localparam int write_entries_log = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAINING = 2'd1,
        DRAINED  = 2'd2
    } tagger_state_t;

endpackage
`default_nettype wire

// File: rtl/request_tagger_if.sv
`default_nettype none
// ============================================================================
// Module      : request_tagger_if
// Description : Host-side request channel and scheduler-side tagged channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface request_tagger_if
    import types_def::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = read_entries_log
);
    logic                   in_valid;
    logic                   in_ready;
    req_type_t              in_type;
    logic [ADDR_WIDTH-1:0]  in_addr;
    logic [DATA_WIDTH-1:0]  in_data;

    logic                   out_valid;
    logic                   out_ready;
    req_type_t              out_type;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [INDEX_WIDTH-1:0] out_index;

    // Host and scheduler side of the environment.
    modport master (
        output in_valid, in_type, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_type, out_addr, out_data, out_index
    );

    // The tagger itself.
    modport slave (
        input  in_valid, in_type, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_type, out_addr, out_data, out_index
    );
endinterface
`default_nettype wire

// File: rtl/request_tagger_counter.sv
`default_nettype none
// ============================================================================
// Module      : tag_credit_counter
// Description : Per-type sequence tag plus outstanding-credit tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_credit_counter #(
    parameter int LOG = 6
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         accept,
    input  wire logic         done,
    output logic [LOG-1:0]    tag,
    output logic [LOG:0]      outstanding,
    output logic              full,
    output logic              underflow
);
    localparam logic [LOG:0] CAPACITY = {1'b1, {LOG{1'b0}}};

    assign full      = (outstanding == CAPACITY);
    assign underflow = done && (outstanding == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag         <= '0;
            outstanding <= '0;
        end else begin
            if (accept)
                tag <= tag + 1'b1;
            // A done against an empty count is dropped rather than wrapping.
            case ({accept, done})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   if (!underflow) outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/request_tagger.sv
`default_nettype none
// ============================================================================
// Module      : request_tagger
// Description : Stamps host reads/writes with in-order tags, tracks credits
//               and quiesces on drain. Optional checks: REQUEST_TAGGER_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module request_tagger
    import types_def::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 32,
    parameter int READ_ENTRIES_LOG  = read_entries_log,
    parameter int WRITE_ENTRIES_LOG = write_entries_log
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    request_tagger_if.slave               bus,
    input  wire logic                     read_done,
    input  wire logic                     write_done,
    input  wire logic                     drain_req,
    output logic                          drain_done,
    output logic [READ_ENTRIES_LOG:0]     rd_outstanding,
    output logic [WRITE_ENTRIES_LOG:0]    wr_outstanding,
    output logic                          err
);
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_DRAINING = DRAINING;
    localparam logic [1:0] ST_DRAINED  = DRAINED;

    logic [1:0]                   state;
    logic [1:0]                   state_next;
    logic                         rd_full;
    logic                         wr_full;
    logic                         rd_underflow;
    logic                         wr_underflow;
    logic [READ_ENTRIES_LOG-1:0]  rd_tag;
    logic [WRITE_ENTRIES_LOG-1:0] wr_tag;
    logic                         type_full;
    logic                         accept;
    logic                         rd_accept;
    logic                         wr_accept;

    assign type_full    = (bus.in_type == REQ_READ) ? rd_full : wr_full;
    assign bus.in_ready = rst_n && (state == ST_RUN) && !drain_req &&
                          (!bus.out_valid || bus.out_ready) && !type_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign rd_accept    = accept && (bus.in_type == REQ_READ);
    assign wr_accept    = accept && (bus.in_type == REQ_WRITE);

    tag_credit_counter #(.LOG(READ_ENTRIES_LOG)) u_rd_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (rd_accept),
        .done        (read_done),
        .tag         (rd_tag),
        .outstanding (rd_outstanding),
        .full        (rd_full),
        .underflow   (rd_underflow)
    );

    tag_credit_counter #(.LOG(WRITE_ENTRIES_LOG)) u_wr_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (wr_accept),
        .done        (write_done),
        .tag         (wr_tag),
        .outstanding (wr_outstanding),
        .full        (wr_full),
        .underflow   (wr_underflow)
    );

    // Output stage: loads on accept, otherwise holds until the scheduler takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_type  <= REQ_READ;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_index <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_type  <= bus.in_type;
            bus.out_addr  <= bus.in_addr;
            bus.out_data  <= bus.in_data;
            bus.out_index <= (bus.in_type == REQ_READ) ? rd_tag
                                                       : READ_ENTRIES_LOG'(wr_tag);
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:
                if (drain_req) state_next = ST_DRAINING;
            ST_DRAINING:
                if (!drain_req)
                    state_next = ST_RUN;
                else if (!bus.out_valid && rd_outstanding == '0 && wr_outstanding == '0)
                    state_next = ST_DRAINED;
            ST_DRAINED:
                if (!drain_req) state_next = ST_RUN;
            default:
                state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    assign drain_done = (state == ST_DRAINED);

`ifdef REQUEST_TAGGER_ERR_CHECK_EN
    logic      stall_seen;
    req_type_t stall_type;
    logic      type_flip;
    logic      err_q;

    // A stalled request must hold its type until it is accepted.
    assign type_flip = stall_seen && bus.in_valid && (bus.in_type != stall_type);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_seen <= 1'b0;
            stall_type <= REQ_READ;
            err_q      <= 1'b0;
        end else begin
            stall_seen <= bus.in_valid && !bus.in_ready;
            stall_type <= bus.in_type;
            if (rd_underflow || wr_underflow || type_flip)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_underflow;
    assign unused_underflow = rd_underflow | wr_underflow;
    assign err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_request_tagger.sv
`default_nettype none
// ============================================================================
// Module      : tb_request_tagger
// Description : Directed self-checking bench for request_tagger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_request_tagger;
    import types_def::*;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int RL = read_entries_log;
    localparam int WL = write_entries_log;

    logic          clk;
    logic          rst_n;
    logic          read_done;
    logic          write_done;
    logic          drain_req;
    logic          drain_done;
    logic [RL:0]   rd_outstanding;
    logic [WL:0]   wr_outstanding;
    logic          err;

    int checks = 0;
    int fails  = 0;

    request_tagger_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INDEX_WIDTH(RL)) bus ();

    request_tagger #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .READ_ENTRIES_LOG(RL), .WRITE_ENTRIES_LOG(WL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .read_done      (read_done),
        .write_done     (write_done),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .rd_outstanding (rd_outstanding),
        .wr_outstanding (wr_outstanding),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input req_type_t t, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_type  = t;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; read_done = 1'b0; write_done = 1'b0; drain_req = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, REQ_READ, '0, '0);
        tick(); tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready actual=%b expected=0", bus.in_ready);
        end
        rst_n = 1'b1;
        checks++;
        if ({bus.out_valid, bus.out_index, rd_outstanding, wr_outstanding, drain_done, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs actual v=%b idx=%0d rd=%0d wr=%0d dd=%b err=%b expected all 0",
                     bus.out_valid, bus.out_index, rd_outstanding, wr_outstanding, drain_done, err);
        end
    endtask

    task automatic test_basic();
        req_type_t       types [5] = '{REQ_READ, REQ_READ, REQ_READ, REQ_WRITE, REQ_WRITE};
        logic [RL-1:0]   idx   [5] = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, types[i], 32'h1000 + 32'(i * 16), 16'hA000 + 16'(i));
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_type !== types[i] || bus.out_index !== idx[i] ||
                bus.out_addr !== 32'h1000 + 32'(i * 16) || bus.out_data !== 16'hA000 + 16'(i)) begin
                fails++;
                $display("FAIL basic_%0d actual v=%b t=%0d idx=%0d a=%h d=%h expected v=1 t=%0d idx=%0d",
                         i, bus.out_valid, bus.out_type, bus.out_index, bus.out_addr, bus.out_data,
                         types[i], idx[i]);
            end
        end
        drive(1'b0, REQ_READ, '0, '0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || rd_outstanding !== 7'd3 || wr_outstanding !== 5'd2) begin
            fails++;
            $display("FAIL basic_counts actual v=%b rd=%0d wr=%0d expected v=0 rd=3 wr=2",
                     bus.out_valid, rd_outstanding, wr_outstanding);
        end
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        drive(1'b1, REQ_READ, 32'hDEAD_0000, 16'h1234);
        tick();
        drive(1'b1, REQ_READ, 32'hBEEF_0000, 16'h5678);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                fails++; $display("FAIL hold_in_ready_%0d actual=%b expected=0", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'hDEAD_0000 || bus.out_data !== 16'h1234 ||
                bus.out_index !== 6'd3 || rd_outstanding !== 7'd4) begin
                fails++;
                $display("FAIL hold_stable_%0d actual v=%b a=%h d=%h idx=%0d rd=%0d expected v=1 a=dead0000 d=1234 idx=3 rd=4",
                         i, bus.out_valid, bus.out_addr, bus.out_data, bus.out_index, rd_outstanding);
            end
        end
        drive(1'b0, REQ_READ, '0, '0);
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, REQ_READ, 32'(i), '0);
            tick();
        end
        checks++;
        if (rd_outstanding !== 7'd64 || bus.out_index !== 6'd63) begin
            fails++;
            $display("FAIL full_count actual rd=%0d idx=%0d expected rd=64 idx=63", rd_outstanding, bus.out_index);
        end
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL full_read_stall actual=%b expected=0", bus.in_ready);
        end
        drive(1'b1, REQ_WRITE, 32'h77, 16'h77);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL full_write_ready actual=%b expected=1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_type !== REQ_WRITE || bus.out_index !== 6'd2 || wr_outstanding !== 5'd3) begin
            fails++;
            $display("FAIL full_write_accept actual t=%0d idx=%0d wr=%0d expected t=1 idx=2 wr=3",
                     bus.out_type, bus.out_index, wr_outstanding);
        end
        drive(1'b1, REQ_READ, 32'h65, '0);
        read_done = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL full_done_same_cycle actual=%b expected=0", bus.in_ready);
        end
        tick();
        read_done = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || rd_outstanding !== 7'd63) begin
            fails++;
            $display("FAIL full_unblock actual rdy=%b rd=%0d expected rdy=1 rd=63", bus.in_ready, rd_outstanding);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 6'd0 || bus.out_addr !== 32'h65 ||
            rd_outstanding !== 7'd64) begin
            fails++;
            $display("FAIL full_wrap actual v=%b idx=%0d a=%h rd=%0d expected v=1 idx=0 a=65 rd=64",
                     bus.out_valid, bus.out_index, bus.out_addr, rd_outstanding);
        end
        drive(1'b0, REQ_READ, '0, '0);
        tick();
    endtask

    task automatic test_simultaneous();
        read_done = 1'b1;
        repeat (59) tick();
        read_done = 1'b0;
        checks++;
        if (rd_outstanding !== 7'd5) begin
            fails++; $display("FAIL simul_setup actual rd=%0d expected 5", rd_outstanding);
        end
        drive(1'b1, REQ_READ, 32'h5, '0);
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        drive(1'b0, REQ_READ, '0, '0);
        checks++;
        if (rd_outstanding !== 7'd5 || bus.out_index !== 6'd1) begin
            fails++;
            $display("FAIL simul_accept_done actual rd=%0d idx=%0d expected rd=5 idx=1", rd_outstanding, bus.out_index);
        end
        tick();
    endtask

    task automatic test_drain();
        read_done = 1'b1; write_done = 1'b1;
        repeat (3) tick();
        write_done = 1'b0;
        repeat (2) tick();
        read_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, REQ_READ, 32'h200 + 32'(i), '0);
            tick();
        end
        drive(1'b0, REQ_READ, '0, '0);
        tick();
        checks++;
        if (rd_outstanding !== 7'd2 || wr_outstanding !== 5'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_setup actual rd=%0d wr=%0d v=%b expected rd=2 wr=0 v=0",
                     rd_outstanding, wr_outstanding, bus.out_valid);
        end
        drain_req = 1'b1;
        drive(1'b1, REQ_READ, 32'h300, '0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL drain_in_ready actual=%b expected=0", bus.in_ready);
        end
        tick();
        drive(1'b0, REQ_READ, '0, '0);
        checks++;
        if (drain_done !== 1'b0 || rd_outstanding !== 7'd2) begin
            fails++;
            $display("FAIL drain_pending actual dd=%b rd=%0d expected dd=0 rd=2", drain_done, rd_outstanding);
        end
        read_done = 1'b1;
        tick(); tick();
        read_done = 1'b0;
        tick();
        checks++;
        if (drain_done !== 1'b1) begin
            fails++; $display("FAIL drain_done actual=%b expected=1", drain_done);
        end
        drain_req = 1'b0;
        tick();
        checks++;
        if (drain_done !== 1'b0) begin
            fails++; $display("FAIL drain_release actual=%b expected=0", drain_done);
        end
        drive(1'b1, REQ_READ, 32'h400, '0);
        tick();
        drive(1'b0, REQ_READ, '0, '0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 6'd4) begin
            fails++;
            $display("FAIL drain_tag_kept actual v=%b idx=%0d expected v=1 idx=4", bus.out_valid, bus.out_index);
        end
        tick();
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef REQUEST_TAGGER_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL err_clean actual=%b expected=0", err);
        end
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (err !== exp_err || wr_outstanding !== 5'd0) begin
                fails++;
                $display("FAIL err_underflow_%0d actual err=%b wr=%0d expected err=%b wr=0",
                         i, err, wr_outstanding, exp_err);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_full();
        test_simultaneous();
        test_drain();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
